// File: rtl/dmem_responder.sv
// Multi-cycle data-memory slave: one word-aligned load/store at a time over
// valid/ready, with LATENCY wait states before the byte-enabled array access.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_error_o,
  output logic        busy_o,
  output logic [31:0] debug_mem_0_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        wr_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;
  logic        error_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, access, wr_en;
  logic        acc_write;
  logic [31:0] acc_addr, acc_wdata, offset;
  logic [3:0]  acc_be;
  logic [29:0] word_idx;
  logic [AW-1:0] mem_idx;
  logic        acc_err;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int unsigned b = 0; b < 4; b++)
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    return res;
  endfunction

  assign accept = (state_q == S_IDLE) && req_valid_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            access  = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          access  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero latency the access happens on the accept edge, so decode the live inputs.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_write = req_write_i;
      acc_addr  = req_addr_i;
      acc_wdata = req_wdata_i;
      acc_be    = req_be_i;
    end else begin
      acc_write = wr_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
  end

  assign offset   = acc_addr - BASE_ADDR;
  assign word_idx = offset[31:2];
  assign mem_idx  = word_idx[AW-1:0];
  assign acc_err  = (offset[1:0] != 2'b00) || (word_idx >= 30'(DEPTH_WORDS));
  assign wr_en    = access && acc_write && !acc_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q   <= 4'(LATENCY);
        wr_q    <= req_write_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        be_q    <= req_be_i;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (access) begin
        rdata_q <= (acc_write || acc_err) ? '0 : mem[mem_idx];
        error_q <= acc_err;
      end else if (state_q == S_RESP && rsp_ready_i) begin
        rdata_q <= '0;
        error_q <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < DEPTH_WORDS; g++) begin : g_word
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        mem[g] <= '0;
      else if (wr_en && mem_idx == AW'(g))
        mem[g] <= merge_bytes(mem[g], acc_wdata, acc_be);
    end
  end

  assign req_ready_o   = (state_q == S_IDLE);
  assign rsp_valid_o   = (state_q == S_RESP);
  assign busy_o        = (state_q != S_IDLE);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_error_o   = error_q;
  assign debug_mem_0_o = mem[0];

endmodule
